// File: rtl/ann_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : ann_result_collector
// Function : Captures passing cascade windows into a result FIFO and merges
//            adjacent same-scale hits. Keeps per-frame face/overflow stats.
// Revision : 1.0
// ============================================================================
module ann_result_collector #(
    parameter int DEPTH      = 64,
    parameter int AW         = 6,
    parameter int MERGE_DIST = 2,
    parameter int HITW       = 4
) (
    input  logic                iClk,
    input  logic                iReset_n,
    input  logic                iWrreq_OM,
    input  logic                iPass,
    input  logic [9:0]          iWin_x,
    input  logic [9:0]          iWin_y,
    input  logic [3:0]          iScale,
    input  logic                iFrame_start,
    input  logic                iRdreq,
    output logic [HITW+23:0]    oRd_data,
    output logic                oRd_valid,
    output logic                oEmpty,
    output logic                oFull,
    output logic [AW:0]         oUsedw,
    output logic [15:0]         oFace_count,
    output logic                oOverflow
);

    localparam int               DW       = HITW + 24;
    localparam logic [AW:0]      FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [HITW-1:0]  HIT_MAX  = '1;
    localparam logic signed [10:0] MD     = 11'(MERGE_DIST);

    logic [DW-1:0]   mem_q [DEPTH];

    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     usedw_q, usedw_d;
    logic            empty_q, empty_d;
    logic            full_q, full_d;
    logic [DW-1:0]   rd_data_q, rd_data_d;
    logic            rd_valid_q, rd_valid_d;
    logic [15:0]     face_q, face_d;
    logic            overflow_q, overflow_d;
    logic            last_valid_q, last_valid_d;
    logic [9:0]      last_x_q, last_x_d;
    logic [9:0]      last_y_q, last_y_d;
    logic [3:0]      last_scale_q, last_scale_d;

    logic              det, pop, pop_last, near, merge, push, drop;
    logic signed [10:0] dx, dy;
    logic [AW-1:0]     last_idx;
    logic [HITW-1:0]   hits_old, hits_new;
    logic [15:0]       face_base;

    always_comb begin
        det      = iWrreq_OM & iPass;
        pop      = iRdreq & ~empty_q;
        pop_last = pop & (usedw_q == (AW+1)'(1));
        dx       = $signed({1'b0, iWin_x}) - $signed({1'b0, last_x_q});
        dy       = $signed({1'b0, iWin_y}) - $signed({1'b0, last_y_q});
        near     = last_valid_q & ~iFrame_start & (iScale == last_scale_q) &
                   (dx >= -MD) & (dx <= MD) & (dy >= -MD) & (dy <= MD);
        // A merge into the entry being popped this cycle becomes a fresh write
        merge    = det & near & ~pop_last;
        push     = det & ~merge & ~full_q;
        drop     = det & ~merge & full_q;
        last_idx = wr_ptr_q - 1'b1;
        hits_old = mem_q[last_idx][DW-1:24];
        hits_new = (hits_old == HIT_MAX) ? hits_old : hits_old + 1'b1;

        wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, pop};
        usedw_d  = usedw_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        empty_d  = (usedw_d == '0);
        full_d   = (usedw_d == FULL_LVL);

        rd_valid_d = pop;
        rd_data_d  = pop ? mem_q[rd_ptr_q] : rd_data_q;
        overflow_d = overflow_q | drop;

        face_base = iFrame_start ? 16'd0 : face_q;
        face_d    = ((merge | push) && face_base != 16'hFFFF) ? face_base + 16'd1
                                                              : face_base;

        last_valid_d = last_valid_q & ~iFrame_start & ~pop_last;
        last_x_d     = last_x_q;
        last_y_d     = last_y_q;
        last_scale_d = last_scale_q;
        if (push || merge) begin
            last_x_d = iWin_x;
            last_y_d = iWin_y;
        end
        if (push) begin
            last_valid_d = 1'b1;
            last_scale_d = iScale;
        end
    end

    always_ff @(posedge iClk) begin
        if (!iReset_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            usedw_q      <= '0;
            empty_q      <= 1'b1;
            full_q       <= 1'b0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            face_q       <= '0;
            overflow_q   <= 1'b0;
            last_valid_q <= 1'b0;
            last_x_q     <= '0;
            last_y_q     <= '0;
            last_scale_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            usedw_q      <= usedw_d;
            empty_q      <= empty_d;
            full_q       <= full_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            face_q       <= face_d;
            overflow_q   <= overflow_d;
            last_valid_q <= last_valid_d;
            last_x_q     <= last_x_d;
            last_y_q     <= last_y_d;
            last_scale_q <= last_scale_d;
        end
    end

    // Storage needs no reset; pointers and occupancy define what is live
    always_ff @(posedge iClk) begin
        if (iReset_n) begin
            if (push)
                mem_q[wr_ptr_q] <= {{{(HITW-1){1'b0}}, 1'b1}, iScale, iWin_y, iWin_x};
            else if (merge)
                mem_q[last_idx][DW-1:24] <= hits_new;
        end
    end

    assign oRd_data    = rd_data_q;
    assign oRd_valid   = rd_valid_q;
    assign oEmpty      = empty_q;
    assign oFull       = full_q;
    assign oUsedw      = usedw_q;
    assign oFace_count = face_q;
    assign oOverflow   = overflow_q;

endmodule
`default_nettype wire

// File: doc/ann_result_collector.md
Name: ann_result_collector

Overview:
Downstream consumer of the ANN cascade controller's output-memory write strobe and pass flag. On every window that passes all stages, it records the window position and scale into an on-chip result FIFO. It merges near-duplicate detections from adjacent windows at the same scale. The host/display side drains results through a registered read port, and the block keeps per-frame face and overflow statistics.

Parameters:
DEPTH, 64, result FIFO entries (power of two)
AW, 6, log2(DEPTH)
MERGE_DIST, 2, max |dx| and |dy| (pixels) for merging into the last stored entry
HITW, 4, width of per-entry hit counter

Ports:
iClk  in  1  clock
iReset_n  in  1  synchronous active-low reset
iWrreq_OM  in  1  one-cycle strobe from cascade controller: window decision final
iPass  in  1  window passed cascade (sampled only with iWrreq_OM)
iWin_x  in  10  current window x origin (stable while iWrreq_OM high)
iWin_y  in  10  current window y origin
iScale  in  4  current pyramid scale index
iFrame_start  in  1  one-cycle pulse at start of a new frame
iRdreq  in  1  pop request from consumer
oRd_data  out  28  {hits[3:0], scale[3:0], y[9:0], x[9:0]}
oRd_valid  out  1  oRd_data valid (one-cycle pulse)
oEmpty  out  1  FIFO empty
oFull  out  1  FIFO full
oUsedw  out  AW+1  occupied entries, 0..DEPTH
oFace_count  out  16  detections accepted this frame (new + merged), saturating
oOverflow  out  1  sticky: a detection was dropped due to full

Behaviour:
- Reset (iReset_n=0 at posedge): pointers=0, oUsedw=0, oEmpty=1, oFull=0, oRd_valid=0, oRd_data=0, oFace_count=0, oOverflow=0, last_valid=0. Memory contents don't care. Reset mid-operation discards all entries.
- Detection event D = iWrreq_OM & iPass. iWrreq_OM with iPass=0 is ignored.
- Merge test, combinational at D: last_valid & scale==last_scale & |iWin_x-last_x|<=MERGE_DIST & |iWin_y-last_y|<=MERGE_DIST.
  - Use 11-bit signed differences. No wrap across 0/1023.
- On D and merge: the entry at wr_ptr-1 increments hits, saturating at 2^HITW-1. x/y/scale are kept from the first hit. No pointer change. last_x/last_y are updated to the new window so a chain of adjacent windows keeps merging.
- On D, no merge, not full: write {hits=1, scale, y, x} at wr_ptr. Then wr_ptr++ (wraps mod DEPTH), oUsedw++. last_* <= this window; last_valid <= 1.
- On D, no merge, full: entry dropped, oOverflow <= 1, pointers unchanged. Full is judged on pre-edge oUsedw, so a simultaneous pop does not make room.
- oFace_count increments (saturating at 0xFFFF) on every D that is written or merged, not on drops.
- Read: iRdreq & ~oEmpty at edge N gives oRd_data = mem[rd_ptr] and oRd_valid=1 in cycle N+1. rd_ptr++ (wrap), oUsedw--.
  - iRdreq while empty is ignored; oRd_valid=0 and oRd_data holds.
- Simultaneous push and pop: both take effect; oUsedw unchanged.
- Pop of the last-written entry: the pop consumes the entry at wr_ptr-1 (oUsedw==1 and no same-cycle push). That clears last_valid.
  - If a merge targets that entry in the same cycle, the merge is cancelled. D is instead treated as a new write (hits=1), and last_valid is set.
- Pop and merge on a different (still resident) entry in the same cycle are independent.
- iFrame_start: last_valid <= 0, oFace_count <= 0. The FIFO is not flushed and oOverflow is unchanged (cleared only by reset).
  - If iFrame_start coincides with D, the frame clear applies first. D is then processed with no merge and counts as 1.
- Flags are registered: oEmpty = (oUsedw==0), oFull = (oUsedw==DEPTH), both valid the cycle after the updating edge.
- All state updates occur only at posedge iClk. No combinational path from iRdreq to oRd_data.

Test Plan:
- Reset, then D at (x=100,y=40,s=2) -> oUsedw=1, oEmpty=0. Pop -> next cycle oRd_valid=1, oRd_data={1,2,40,100}, oEmpty=1.
- D at (100,40,2), (101,41,2), (103,40,2) -> oUsedw=1, oFace_count=3. Pop gives hits=3, x=100; 3rd merges because last is (101,41).
- D at (100,40,2), then (100,40,3), then (110,40,3) -> 3 separate entries; scale change and dx=10 both block merge.
- Fill DEPTH=64 distinct detections (x step 10) then one more -> oFull=1, oUsedw=64, oOverflow=1, oFace_count=64. Same-cycle pop+push at full -> push dropped, oUsedw=63.
- 16 merging hits on one entry -> hits saturates at 15, oFace_count=16. iFrame_start, then an adjacent D -> new entry hits=1, oFace_count=1.
- Single resident entry, pop and merging D in the same cycle -> popped data hits=1, new entry written hits=1, oUsedw=1. iRdreq on empty -> oRd_valid stays 0.
